// File: rtl/alu_exec_pipe_pkg.sv
// ----------------------------------------------------------------------------
// alu_exec_pipe_pkg
//   Shared constants and stage records for the ALU execution lane.
//   - DATA_W / PREG_W / ROB_W : operand, physical-register and ROB tag widths
//   - ALU_ADD .. ALU_LUI      : 4-bit opcode values carried on Conf
//   - ex_stage_t / cdb_stage_t: contents of the RR/EX and CDB registers
// ----------------------------------------------------------------------------
package alu_exec_pipe_pkg;

    localparam int DATA_W  = 32;
    localparam int PREG_W  = 6;
    localparam int ROB_W   = 6;
    localparam int CONF_W  = 4;
    localparam int SHAMT_W = $clog2(DATA_W);

    localparam logic [CONF_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [CONF_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [CONF_W-1:0] ALU_SLT  = 4'd2;
    localparam logic [CONF_W-1:0] ALU_SLTU = 4'd3;
    localparam logic [CONF_W-1:0] ALU_AND  = 4'd4;
    localparam logic [CONF_W-1:0] ALU_OR   = 4'd5;
    localparam logic [CONF_W-1:0] ALU_NOR  = 4'd6;
    localparam logic [CONF_W-1:0] ALU_XOR  = 4'd7;
    localparam logic [CONF_W-1:0] ALU_SLL  = 4'd8;
    localparam logic [CONF_W-1:0] ALU_SRL  = 4'd9;
    localparam logic [CONF_W-1:0] ALU_SRA  = 4'd10;
    localparam logic [CONF_W-1:0] ALU_LUI  = 4'd11;

    // Operands are already resolved (PRF / bypass / immediate) when latched.
    typedef struct packed {
        logic                valid;
        logic                regwr;
        logic [PREG_W-1:0]   pd;
        logic [ROB_W-1:0]    tag;
        logic [CONF_W-1:0]   conf;
        logic [DATA_W-1:0]   op_a;
        logic [DATA_W-1:0]   op_b;
    } ex_stage_t;

    typedef struct packed {
        logic                valid;
        logic                regwr;
        logic [PREG_W-1:0]   pd;
        logic [DATA_W-1:0]   data;
        logic [ROB_W-1:0]    tag;
    } cdb_stage_t;

endpackage

// File: rtl/alu_exec_pipe_if.sv
// ----------------------------------------------------------------------------
// alu_exec_pipe_if
//   Bundle between the ALU issue queue / PRF (master side) and the ALU
//   execution lane (slave side).
//   - awake group : ready_awake, Pj/Pk/Pd_awake, imm_awake, Conf_awake,
//                   isImm_awake, RegWr_awake, tag_rob_awake   (master -> slave)
//   - PRF read    : prf_raddr_j/k (slave -> master), prf_rdata_j/k (master -> slave)
//   - CDB lane    : ready_cdb, RegWr_cdb, Pd_cdb, data_cdb, tag_rob_cdb
//                   (slave -> master)
// ----------------------------------------------------------------------------
interface alu_exec_pipe_if;
    import alu_exec_pipe_pkg::*;

    logic                ready_awake;
    logic [PREG_W-1:0]   Pj_awake;
    logic [PREG_W-1:0]   Pk_awake;
    logic [PREG_W-1:0]   Pd_awake;
    logic [DATA_W-1:0]   imm_awake;
    logic [CONF_W-1:0]   Conf_awake;
    logic                isImm_awake;
    logic                RegWr_awake;
    logic [ROB_W-1:0]    tag_rob_awake;

    logic [PREG_W-1:0]   prf_raddr_j;
    logic [PREG_W-1:0]   prf_raddr_k;
    logic [DATA_W-1:0]   prf_rdata_j;
    logic [DATA_W-1:0]   prf_rdata_k;

    logic                ready_cdb;
    logic                RegWr_cdb;
    logic [PREG_W-1:0]   Pd_cdb;
    logic [DATA_W-1:0]   data_cdb;
    logic [ROB_W-1:0]    tag_rob_cdb;

    modport master (
        output ready_awake, Pj_awake, Pk_awake, Pd_awake, imm_awake,
               Conf_awake, isImm_awake, RegWr_awake, tag_rob_awake,
               prf_rdata_j, prf_rdata_k,
        input  prf_raddr_j, prf_raddr_k,
               ready_cdb, RegWr_cdb, Pd_cdb, data_cdb, tag_rob_cdb
    );

    modport slave (
        input  ready_awake, Pj_awake, Pk_awake, Pd_awake, imm_awake,
               Conf_awake, isImm_awake, RegWr_awake, tag_rob_awake,
               prf_rdata_j, prf_rdata_k,
        output prf_raddr_j, prf_raddr_k,
               ready_cdb, RegWr_cdb, Pd_cdb, data_cdb, tag_rob_cdb
    );

endinterface

// File: rtl/alu_exec_pipe_alu_core.sv
// ----------------------------------------------------------------------------
// alu_core
//   Purely combinational 32-bit ALU shared by the ALU execution lanes.
//   - op_a, op_b : resolved operands
//   - conf       : opcode (ALU_ADD .. ALU_LUI, 12-15 reserved -> 0)
//   - result     : wrap-around result, carry discarded
// ----------------------------------------------------------------------------
module alu_core
    import alu_exec_pipe_pkg::*;
(
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [CONF_W-1:0] conf,
    output logic [DATA_W-1:0] result
);

    // Shifts only look at the low bits of B, so B=33 shifts by 1.
    logic [SHAMT_W-1:0] shamt;
    assign shamt = op_b[SHAMT_W-1:0];

    always_comb begin
        // NOTE: default assignment first so no path leaves result unassigned (no latch).
        result = '0;
        case (conf)
            ALU_ADD:  result = op_a + op_b;
            ALU_SUB:  result = op_a - op_b;
            ALU_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
            ALU_AND:  result = op_a & op_b;
            ALU_OR:   result = op_a | op_b;
            ALU_NOR:  result = ~(op_a | op_b);
            ALU_XOR:  result = op_a ^ op_b;
            ALU_SLL:  result = op_a << shamt;
            ALU_SRL:  result = op_a >> shamt;
            ALU_SRA:  result = $unsigned($signed(op_a) >>> shamt);
            ALU_LUI:  result = op_b;  // immediate arrives pre-shifted from decode
            default:  result = '0;    // reserved opcodes still broadcast, with data 0
        endcase
    end

endmodule

// File: rtl/alu_exec_pipe.sv
// ----------------------------------------------------------------------------
// alu_exec_pipe
//   Two-stage ALU execution lane: register-read (with CDB bypass) then
//   execute, broadcasting on a dedicated CDB lane two cycles after issue.
//   - clk, rst : clock, asynchronous active-low reset
//   - flush    : synchronous pipeline clear (mispredict / exception)
//   - bus      : awake inputs, PRF read port and CDB outputs (slave side)
// ----------------------------------------------------------------------------
module alu_exec_pipe
    import alu_exec_pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    alu_exec_pipe_if.slave   bus
);

    ex_stage_t   ex_d, ex_q;
    cdb_stage_t  cdb_d, cdb_q;
    logic        byp_j, byp_k;
    logic [DATA_W-1:0] ex_result;

    // PRF is read combinationally in the RR cycle.
    assign bus.prf_raddr_j = bus.Pj_awake;
    assign bus.prf_raddr_k = bus.Pk_awake;

    // The result on the CDB this cycle has not reached the PRF yet, so a
    // matching source register must take it from the CDB instead.
    assign byp_j = cdb_q.valid && cdb_q.regwr && (cdb_q.pd == bus.Pj_awake);
    assign byp_k = cdb_q.valid && cdb_q.regwr && (cdb_q.pd == bus.Pk_awake);

    always_comb begin
        ex_d       = '0;
        ex_d.valid = 1'b1;
        ex_d.regwr = bus.RegWr_awake;
        ex_d.pd    = bus.Pd_awake;
        ex_d.tag   = bus.tag_rob_awake;
        ex_d.conf  = bus.Conf_awake;
        ex_d.op_a  = byp_j ? cdb_q.data : bus.prf_rdata_j;
        if (bus.isImm_awake) begin
            ex_d.op_b = bus.imm_awake;
        end else begin
            ex_d.op_b = byp_k ? cdb_q.data : bus.prf_rdata_k;
        end
    end

    alu_core u_alu_core (
        .op_a   (ex_q.op_a),
        .op_b   (ex_q.op_b),
        .conf   (ex_q.conf),
        .result (ex_result)
    );

    always_comb begin
        cdb_d       = '0;
        cdb_d.valid = 1'b1;
        cdb_d.regwr = ex_q.regwr;
        cdb_d.pd    = ex_q.pd;
        cdb_d.data  = ex_result;
        cdb_d.tag   = ex_q.tag;
    end

    // Empty slots are stored as all-zero so the CDB shows zeros when idle.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments so both stages update from pre-edge values.
        if (!rst) begin
            ex_q  <= '0;
            cdb_q <= '0;
        end else if (flush) begin
            ex_q  <= '0;
            cdb_q <= '0;
        end else begin
            ex_q  <= bus.ready_awake ? ex_d  : '0;
            cdb_q <= ex_q.valid      ? cdb_d : '0;
        end
    end

    assign bus.ready_cdb   = cdb_q.valid;
    assign bus.RegWr_cdb   = cdb_q.regwr;
    assign bus.Pd_cdb      = cdb_q.pd;
    assign bus.data_cdb    = cdb_q.data;
    assign bus.tag_rob_cdb = cdb_q.tag;

endmodule

// File: tb/tb_alu_exec_pipe.sv
// ----------------------------------------------------------------------------
// tb_alu_exec_pipe
//   Bench for alu_exec_pipe: directed scenarios plus randomized traffic
//   compared against a cycle-indexed scoreboard of expected CDB contents.
// ----------------------------------------------------------------------------
module tb_alu_exec_pipe;
    import alu_exec_pipe_pkg::*;

    typedef struct packed {
        logic        v;
        logic        regwr;
        logic [5:0]  pd;
        logic [31:0] data;
        logic [5:0]  tag;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    alu_exec_pipe_if bus ();

    alu_exec_pipe dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    logic [31:0] prf [64];
    assign bus.prf_rdata_j = prf[bus.prf_raddr_j];
    assign bus.prf_rdata_k = prf[bus.prf_raddr_k];

    int total = 0;
    int bad   = 0;

    // Expected CDB contents: pend[c % 4] is what the lane shows in cycle c.
    res_t pend [4];
    res_t exp_now;
    int   cyc = 0;

    localparam int N_SWEEP = 12;
    localparam logic [3:0]  SWEEP_CONF [N_SWEEP] = '{4'd2, 4'd3, 4'd10, 4'd9, 4'd8, 4'd6,
                                                      4'd9, 4'd8, 4'd13, 4'd11, 4'd1, 4'd0};
    localparam logic [31:0] SWEEP_IMM  [N_SWEEP] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1,
                                                      32'd33, 32'd33, 32'd1, 32'h12345000,
                                                      32'd1, 32'h80000000};
    localparam logic [31:0] SWEEP_EXP  [N_SWEEP] = '{32'd1, 32'd0, 32'hC0000000, 32'h40000000,
                                                      32'd0, 32'h7FFFFFFE, 32'h40000000, 32'd0,
                                                      32'd0, 32'h12345000, 32'h7FFFFFFF, 32'd0};

    function automatic res_t mk(logic v, logic w, logic [5:0] pd, logic [31:0] d, logic [5:0] t);
        res_t r;
        r.v = v; r.regwr = w; r.pd = pd; r.data = d; r.tag = t;
        return r;
    endfunction

    function automatic res_t cdb_word();
        return mk(bus.ready_cdb, bus.RegWr_cdb, bus.Pd_cdb, bus.data_cdb, bus.tag_rob_cdb);
    endfunction

    // Behavioural ALU written from the opcode table.
    function automatic logic [31:0] ref_alu(logic [3:0] conf, logic [31:0] a, logic [31:0] b);
        int          sh;
        logic [31:0] r;
        sh = int'(b % 32);
        case (conf)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3:  return (a < b) ? 32'd1 : 32'd0;
            4'd4:  return a & b;
            4'd5:  return a | b;
            4'd6:  return ~(a | b);
            4'd7:  return a ^ b;
            4'd8:  return a << sh;
            4'd9:  return a >> sh;
            4'd10: begin
                r = a >> sh;
                if (a[31]) r = r | ~(32'hFFFFFFFF >> sh);
                return r;
            end
            4'd11: return b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive_uop(input logic [3:0] conf, input logic [5:0] pj, input logic [5:0] pk,
                             input logic [5:0] pd, input logic [31:0] imm, input logic isimm,
                             input logic regwr, input logic [5:0] tag);
        bus.ready_awake   = 1'b1;
        bus.Conf_awake    = conf;
        bus.Pj_awake      = pj;
        bus.Pk_awake      = pk;
        bus.Pd_awake      = pd;
        bus.imm_awake     = imm;
        bus.isImm_awake   = isimm;
        bus.RegWr_awake   = regwr;
        bus.tag_rob_awake = tag;
    endtask

    task automatic drive_idle();
        bus.ready_awake   = 1'b0;
        bus.Conf_awake    = '0;
        bus.Pj_awake      = '0;
        bus.Pk_awake      = '0;
        bus.Pd_awake      = '0;
        bus.imm_awake     = '0;
        bus.isImm_awake   = 1'b0;
        bus.RegWr_awake   = 1'b0;
        bus.tag_rob_awake = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) pend[i] = '0;
        exp_now = '0;
    endtask

    // Records the outcome of this cycle's inputs, then advances one cycle
    // (to #1 after the next rising edge).
    task automatic tick();
        logic [31:0] a, b;
        if (flush) begin
            pend[(cyc + 1) % 4] = '0;
            pend[(cyc + 2) % 4] = '0;
        end else if (bus.ready_awake) begin
            a = (exp_now.v && exp_now.regwr && exp_now.pd == bus.Pj_awake) ? exp_now.data
                                                                             : prf[bus.Pj_awake];
            if (bus.isImm_awake)
                b = bus.imm_awake;
            else
                b = (exp_now.v && exp_now.regwr && exp_now.pd == bus.Pk_awake) ? exp_now.data
                                                                                 : prf[bus.Pk_awake];
            pend[(cyc + 2) % 4] = mk(1'b1, bus.RegWr_awake, bus.Pd_awake,
                                     ref_alu(bus.Conf_awake, a, b), bus.tag_rob_awake);
        end else begin
            pend[(cyc + 2) % 4] = '0;
        end
        pend[cyc % 4] = '0;
        @(posedge clk);
        #1;
        cyc++;
        exp_now = pend[cyc % 4];
    endtask

    task automatic test_reset();
        res_t got;
        drive_idle();
        model_reset();
        #2;
        got = cdb_word();
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", got);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            got = cdb_word();
            total++;
            if (got !== '0) begin
                bad++;
                $display("FAIL idle_after_reset[%0d]: got %h want 0", i, got);
            end
        end
    endtask

    task automatic test_add();
        res_t got;
        prf[3] = 32'd5;
        drive_uop(4'd0, 6'd3, 6'd0, 6'd10, 32'd7, 1'b1, 1'b1, 6'd4);
        tick();
        drive_idle();
        got = cdb_word();
        total++;
        if (got.v !== 1'b0) begin
            bad++;
            $display("FAIL add_latency_t1: got ready_cdb=%b want 0", got.v);
        end
        tick();
        got = cdb_word();
        total++;
        if (got !== mk(1'b1, 1'b1, 6'd10, 32'd12, 6'd4)) begin
            bad++;
            $display("FAIL add_result: got %h want %h", got, mk(1'b1, 1'b1, 6'd10, 32'd12, 6'd4));
        end
        tick();
        got = cdb_word();
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL add_single_broadcast: got %h want 0", got);
        end
    endtask

    task automatic test_back_to_back();
        res_t got;
        prf[1] = 32'd9; prf[2] = 32'd2; prf[20] = 32'd0; prf[22] = 32'd100;
        // SUB 9-2 -> Pd 20, then a uop reading Pd 20 on both sources while
        // the CDB carries it and the PRF still holds 0.
        drive_uop(4'd1, 6'd1, 6'd2, 6'd20, 32'd0, 1'b0, 1'b1, 6'd7);
        tick();
        drive_idle();
        tick();
        got = cdb_word();
        total++;
        if (got !== mk(1'b1, 1'b1, 6'd20, 32'd7, 6'd7)) begin
            bad++;
            $display("FAIL sub_result: got %h want %h", got, mk(1'b1, 1'b1, 6'd20, 32'd7, 6'd7));
        end
        drive_uop(4'd0, 6'd20, 6'd20, 6'd21, 32'd0, 1'b0, 1'b1, 6'd8);
        tick();
        drive_idle();
        tick();
        got = cdb_word();
        total++;
        if (got !== mk(1'b1, 1'b1, 6'd21, 32'd14, 6'd8)) begin
            bad++;
            $display("FAIL bypass_both: got %h want %h", got, mk(1'b1, 1'b1, 6'd21, 32'd14, 6'd8));
        end
        // RegWr=0 result completes in the ROB but must not feed a bypass.
        drive_uop(4'd0, 6'd1, 6'd0, 6'd22, 32'd1, 1'b1, 1'b0, 6'd9);
        tick();
        drive_idle();
        tick();
        got = cdb_word();
        total++;
        if (got !== mk(1'b1, 1'b0, 6'd22, 32'd10, 6'd9)) begin
            bad++;
            $display("FAIL no_regwr_broadcast: got %h want %h", got, mk(1'b1, 1'b0, 6'd22, 32'd10, 6'd9));
        end
        drive_uop(4'd0, 6'd22, 6'd0, 6'd23, 32'd0, 1'b1, 1'b1, 6'd10);
        tick();
        drive_idle();
        tick();
        got = cdb_word();
        total++;
        if (got !== mk(1'b1, 1'b1, 6'd23, 32'd100, 6'd10)) begin
            bad++;
            $display("FAIL no_bypass_without_regwr: got %h want %h", got, mk(1'b1, 1'b1, 6'd23, 32'd100, 6'd10));
        end
    endtask

    task automatic test_opcode_sweep();
        res_t got;
        prf[5] = 32'h80000000;
        for (int i = 0; i <= N_SWEEP; i++) begin
            if (i < N_SWEEP)
                drive_uop(SWEEP_CONF[i], 6'd5, 6'd0, 6'd30, SWEEP_IMM[i], 1'b1, 1'b1, 6'(i));
            else
                drive_idle();
            tick();
            if (i >= 1) begin
                got = cdb_word();
                total++;
                if (got !== mk(1'b1, 1'b1, 6'd30, SWEEP_EXP[i-1], 6'(i-1))) begin
                    bad++;
                    $display("FAIL sweep_conf%0d: got %h want %h", SWEEP_CONF[i-1], got,
                             mk(1'b1, 1'b1, 6'd30, SWEEP_EXP[i-1], 6'(i-1)));
                end
            end
        end
        drive_idle();
        tick();
    endtask

    task automatic test_flush();
        res_t got;
        drive_uop(4'd0, 6'd1, 6'd0, 6'd40, 32'd1, 1'b1, 1'b1, 6'd1);   // X
        tick();
        drive_uop(4'd0, 6'd1, 6'd0, 6'd42, 32'd2, 1'b1, 1'b1, 6'd2);   // A
        tick();
        drive_uop(4'd0, 6'd1, 6'd0, 6'd43, 32'd3, 1'b1, 1'b1, 6'd5);   // B, flushed
        flush = 1'b1;
        got = cdb_word();
        total++;
        if (got !== mk(1'b1, 1'b1, 6'd40, 32'd10, 6'd1)) begin
            bad++;
            $display("FAIL flush_cycle_visible: got %h want %h", got, mk(1'b1, 1'b1, 6'd40, 32'd10, 6'd1));
        end
        tick();
        flush = 1'b0;
        drive_uop(4'd0, 6'd2, 6'd0, 6'd41, 32'd3, 1'b1, 1'b1, 6'd3);   // C
        got = cdb_word();
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL flush_drop_1: got %h want 0", got);
        end
        tick();
        drive_idle();
        got = cdb_word();
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL flush_drop_2: got %h want 0", got);
        end
        tick();
        got = cdb_word();
        total++;
        if (got !== mk(1'b1, 1'b1, 6'd41, 32'd5, 6'd3)) begin
            bad++;
            $display("FAIL after_flush: got %h want %h", got, mk(1'b1, 1'b1, 6'd41, 32'd5, 6'd3));
        end
        tick();
    endtask

    task automatic test_async_reset();
        res_t got;
        drive_uop(4'd0, 6'd1, 6'd0, 6'd50, 32'd1, 1'b1, 1'b1, 6'd11);
        tick();
        drive_uop(4'd7, 6'd1, 6'd0, 6'd51, 32'd1, 1'b1, 1'b1, 6'd12);
        tick();
        drive_idle();
        got = cdb_word();
        total++;
        if (got.v !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_inflight: got ready_cdb=%b want 1", got.v);
        end
        rst = 1'b0;
        #1;
        got = cdb_word();
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL async_reset_immediate: got %h want 0", got);
        end
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            got = cdb_word();
            total++;
            if (got !== '0) begin
                bad++;
                $display("FAIL after_async_reset[%0d]: got %h want 0", i, got);
            end
        end
    endtask

    task automatic test_random();
        res_t got;
        for (int r = 0; r < 8; r++) prf[r] = $urandom();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0)
                drive_uop(4'($urandom_range(0, 15)), 6'($urandom_range(0, 7)),
                          6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
                          $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          6'($urandom_range(0, 63)));
            else
                drive_idle();
            flush = ($urandom_range(0, 19) == 0);
            tick();
            got = cdb_word();
            total++;
            if (got !== exp_now) begin
                bad++;
                $display("FAIL random[%0d]: got %h want %h", i, got, exp_now);
            end
        end
        flush = 1'b0;
        drive_idle();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) prf[i] = '0;
        test_reset();
        test_add();
        test_back_to_back();
        test_opcode_sweep();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
